// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO read-side adapter.
package fifo_rd_pkg;

  localparam int unsigned DEFAULT_FIFO_WIDTH = 16;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;
  localparam int unsigned OCC_WIDTH          = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } fifo_rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head drives the output word, tail absorbs FIFO read data.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_FIFO_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 push,
  input  logic [WIDTH-1:0]     din,
  input  logic                 pop,
  output logic [OCC_WIDTH-1:0] occ,
  output logic [WIDTH-1:0]     head
);

  logic [WIDTH-1:0]     q0;
  logic [WIDTH-1:0]     q1;
  logic [OCC_WIDTH-1:0] occ_q;

  // clear wins over push/pop; push with pop keeps occupancy constant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0    <= '0;
      q1    <= '0;
      occ_q <= '0;
    end else if (clear) begin
      occ_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == OCC_WIDTH'(0)) q0 <= din;
          else                        q1 <= din;
          occ_q <= occ_q + OCC_WIDTH'(1);
        end
        2'b01: begin
          q0    <= q1;
          occ_q <= occ_q - OCC_WIDTH'(1);
        end
        2'b11: begin
          if (occ_q == OCC_WIDTH'(2)) begin
            q0 <= q1;
            q1 <= din;
          end else begin
            q0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = occ_q;
  assign head = q0;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Read-side FIFO adapter: issues rd_en, absorbs read latency, emits a valid/ready stream.
// Optional statistics (rd_count, underflow_seen) built when FIFO_RD_ADAPTER_STATS_EN is defined.
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_seen
);

  localparam int unsigned PEND_WIDTH = OCC_WIDTH + 1;

  fifo_rd_state_e        state_q;
  fifo_rd_state_e        state_d;
  logic                  inflight;
  logic                  busy_q;
  logic                  pop;
  logic                  push;
  logic [OCC_WIDTH-1:0]  occ;
  logic [PEND_WIDTH-1:0] occ_left;
  logic [PEND_WIDTH-1:0] occ_pend;

  assign m_valid  = (occ != OCC_WIDTH'(0));
  assign pop      = m_valid && m_ready;
  // A word still in flight while flushing is dropped on arrival
  assign push     = inflight && !flush && (state_q != FLUSH);
  assign occ_left = PEND_WIDTH'(occ) - PEND_WIDTH'(pop);
  assign occ_pend = occ_left + PEND_WIDTH'(inflight);

  assign fifo_rd_en = (state_q == ACTIVE) && !fifo_empty && !flush &&
                      (occ_pend < PEND_WIDTH'(2));

  fifo_rd_skid #(.WIDTH(FIFO_WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (push),
    .din   (fifo_data_out),
    .pop   (pop),
    .occ   (occ),
    .head  (m_data)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush)            state_d = FLUSH;
        else if (!fifo_empty) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (flush) state_d = FLUSH;
        else if (fifo_empty && (occ_left == PEND_WIDTH'(0)) && !inflight) state_d = IDLE;
      end
      FLUSH: begin
        if (flush)          state_d = FLUSH;
        else if (!inflight) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      inflight <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= fifo_rd_en;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [CNT_WIDTH-1:0] rd_count_q;
  logic                 underflow_q;

  // Delivered-word counter wraps; underflow flag is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (pop)            rd_count_q  <= rd_count_q + CNT_WIDTH'(1);
      if (fifo_underflow) underflow_q <= 1'b1;
    end
  end

  assign rd_count       = rd_count_q;
  assign underflow_seen = underflow_q;
`else
  logic unused_underflow;
  assign unused_underflow = fifo_underflow;
  assign rd_count         = '0;
  assign underflow_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Scoreboard bench for fifo_rd_adapter with a behavioural FIFO and stream model.
module tb_fifo_rd_adapter;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 16;
`ifdef FIFO_RD_ADAPTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_underflow = 1'b0;
  logic          fifo_rd_en;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic          busy;
  logic [CW-1:0] rd_count;
  logic          underflow_seen;

  fifo_rd_adapter #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .flush          (flush),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .busy           (busy),
    .rd_count       (rd_count),
    .underflow_seen (underflow_seen)
  );

  always #5 clk = ~clk;

  // Stimulus-side FIFO write port and forced underflow
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         force_uf = 1'b0;

  // Model state: FIFO contents, words written but not yet delivered
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] data_nxt = '0;
  logic         empty_nxt = 1'b1;
  logic         uf_nxt = 1'b0;

  int            n_vec = 0;
  int            n_fail = 0;
  int            rd_pulses = 0;
  int            run = 0;
  int            max_run = 0;
  logic [CW-1:0] cnt_exp = '0;
  logic          uf_exp = 1'b0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_flush = 1'b0;
  logic [W-1:0]  prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Synchronous FIFO outputs change only on the clock edge
  always @(posedge clk) begin
    fifo_data_out  <= data_nxt;
    fifo_empty     <= empty_nxt;
    fifo_underflow <= uf_nxt;
  end

  // Monitor: samples one time unit before each rising edge and advances the model
  task automatic mon_step();
    bit pop_now;
    int n_drop;
    pop_now = m_valid && m_ready;
    chk("rd_count", 32'(rd_count), STATS ? 32'(cnt_exp) : 32'd0);
    chk("underflow_seen", 32'(underflow_seen), 32'(uf_exp));
    if (prev_flush) begin
      chk("flush_valid_drop", 32'(m_valid), 32'd0);
    end else if (prev_valid && !prev_ready) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_data));
    end
    if (pop_now) begin
      chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("data", 32'(m_data), 32'(exp_q.pop_front()));
      run++;
      if (run > max_run) max_run = run;
      cnt_exp = cnt_exp + CW'(1);
    end else begin
      run = 0;
    end
    if (flush) begin
      n_drop = exp_q.size() - fq.size();
      repeat (n_drop) void'(exp_q.pop_front());
    end
    uf_nxt = force_uf || (fifo_rd_en && fq.size() == 0);
    if (fifo_rd_en) begin
      rd_pulses++;
      chk("rd_en_nonempty", 32'(fq.size() > 0), 32'd1);
      if (fq.size() > 0) data_nxt = fq.pop_front();
    end
    if (wr_en) begin
      fq.push_back(wr_data);
      exp_q.push_back(wr_data);
    end
    empty_nxt = (fq.size() == 0);
    chk("occupancy", 32'((exp_q.size() - fq.size()) <= 2), 32'd1);
    if (STATS && fifo_underflow) uf_exp = 1'b1;
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
    prev_flush = flush;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) mon_step();
    end
  end

  task automatic write_words(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = base + W'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fq.size() == 0 && !busy) break;
    end
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("idle_after_drain", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int lat;
    int n_drop;

    repeat (2) @(negedge clk);
    chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd_count", 32'(rd_count), 32'd0);
    chk("reset_uf", 32'(underflow_seen), 32'd0);
    rst_n = 1'b1;

    // Streaming at full rate
    m_ready = 1'b1;
    run = 0;
    max_run = 0;
    write_words(8, 16'h0001);
    wait_drain();
    chk("stream_run", 32'(max_run), 32'd8);
    chk("stream_rd_count", 32'(rd_count), STATS ? 32'd8 : 32'd0);

    // Back-pressure: only two reads issued, head held
    p = rd_pulses;
    m_ready = 1'b0;
    write_words(8, 16'h0001);
    repeat (6) @(negedge clk);
    chk("bp_rd_pulses", 32'(rd_pulses - p), 32'd2);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_data", 32'(m_data), 32'h0001);
    m_ready = 1'b1;
    wait_drain();

    // Single word: latency and one read
    p = rd_pulses;
    lat = 0;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 16'h00a5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      #4;
      if (m_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd4);
    wait_drain();
    chk("single_rd_pulses", 32'(rd_pulses - p), 32'd1);

    // Flush with one word held and one in flight
    m_ready = 1'b0;
    write_words(3, 16'h0011);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", 32'(busy), 32'd0);
    m_ready = 1'b1;
    wait_drain();

    // Randomised traffic with back-pressure and occasional flush
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      m_ready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 31) == 0);
      wr_en   = (fq.size() < 8) && ($urandom_range(0, 1) == 1);
      wr_data = W'($urandom);
    end
    @(negedge clk);
    flush   = 1'b0;
    wr_en   = 1'b0;
    m_ready = 1'b1;
    wait_drain();

    // Asynchronous reset mid-stream
    write_words(4, 16'h0100);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_uf", 32'(underflow_seen), 32'd0);
    n_drop = exp_q.size() - fq.size();
    repeat (n_drop) void'(exp_q.pop_front());
    cnt_exp    = '0;
    uf_exp     = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("post_reset_valid", 32'(m_valid), 32'd0);
    wait_drain();

    // Forced underflow pulse
    @(negedge clk);
    force_uf = 1'b1;
    @(negedge clk);
    force_uf = 1'b0;
    repeat (4) @(negedge clk);
    chk("uf_sticky", 32'(underflow_seen), STATS ? 32'd1 : 32'd0);
    write_words(2, 16'h0200);
    wait_drain();
    chk("uf_still_set", 32'(underflow_seen), STATS ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
